// File: rtl/restador_serie_pkg.sv
// Shared types and helpers for the bit-serial subtractor restador_serie.
package restador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/restador_serie_semirestador.sv
// Half subtractor: dif = x - y (one bit), bor set when x < y.
module semirestador (
  input  logic x,
  input  logic y,
  output logic dif,
  output logic bor
);

  assign dif = x ^ y;
  assign bor = ~x & y;

endmodule

// File: rtl/restador_serie.sv
// Bit-serial unsigned subtractor A - B, LSB first, one bit per clock.
// Optional two's-complement overflow output enabled by RESTADOR_SIGNED_OVF_EN.
module restador_serie
  import restador_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef RESTADOR_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             bin_r;
  logic [CW-1:0]    cnt_r;

`ifdef RESTADOR_SIGNED_OVF_EN
  logic a_msb_r;
  logic b_msb_r;
`endif

  logic d1_s;
  logic b1_s;
  logic d_s;
  logic b2_s;
  logic bout_s;

  // Full-subtractor bit cell: (a_i - b_i) then minus the incoming borrow.
  semirestador u_hs0 (
    .x   (a_r[0]),
    .y   (b_r[0]),
    .dif (d1_s),
    .bor (b1_s)
  );

  semirestador u_hs1 (
    .x   (d1_s),
    .y   (bin_r),
    .dif (d_s),
    .bor (b2_s)
  );

  assign bout_s = b1_s | b2_s;

  // Control FSM, serial datapath and held result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      bin_r   <= 1'b0;
      cnt_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
`ifdef RESTADOR_SIGNED_OVF_EN
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE, FIN: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            bin_r   <= 1'b0;
            cnt_r   <= '0;
            busy    <= 1'b1;
            state_r <= SHIFT;
`ifdef RESTADOR_SIGNED_OVF_EN
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b[WIDTH-1];
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          a_r   <= {1'b0, a_r[WIDTH-1:1]};
          b_r   <= {1'b0, b_r[WIDTH-1:1]};
          res_r <= {d_s, res_r[WIDTH-1:1]};
          bin_r <= bout_s;
          cnt_r <= cnt_r + CW'(1);
          // Final bit: publish the completed word straight from the cell output.
          if (cnt_r == LAST) begin
            diff    <= {d_s, res_r[WIDTH-1:1]};
            borrow  <= bout_s;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= FIN;
`ifdef RESTADOR_SIGNED_OVF_EN
            ovf     <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
`endif
          end else begin
            state_r <= SHIFT;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restador_serie.sv
// Randomized self-checking bench for restador_serie against a behavioural model.
module tb_restador_serie;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef RESTADOR_SIGNED_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  restador_serie #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef RESTADOR_SIGNED_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining edges until result, result computed arithmetically.
  bit           m_valid = 1'b0;
  int           m_rem = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_diff = '0;
  bit           m_borrow = 1'b0;
  bit           m_ovf = 1'b0;
  logic [W-1:0] pa = '0;
  logic [W-1:0] pb = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b1;
      m_rem    <= 0;
      m_done   <= 1'b0;
      m_diff   <= '0;
      m_borrow <= 1'b0;
      m_ovf    <= 1'b0;
    end else if (m_valid) begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_diff   <= pa - pb;
          m_borrow <= (pa < pb);
          m_ovf    <= (pa[W-1] != pb[W-1]) && (((pa - pb) >> (W - 1)) != {{(W-1){1'b0}}, pa[W-1]});
          m_done   <= 1'b1;
        end
      end else if (start) begin
        pa    <= a;
        pb    <= b;
        m_rem <= W;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 32'(busy), 32'(m_rem != 0));
      chk("done", 32'(done), 32'(m_done));
      chk("diff", 32'(diff), 32'(m_diff));
      chk("borrow", 32'(borrow), 32'(m_borrow));
`ifdef RESTADOR_SIGNED_OVF_EN
      chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
    end
  end

  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int lat;
    int nbusy;
    bit seen;
    a = xa;
    b = xb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    lat = 0;
    nbusy = 0;
    seen = 1'b0;
    while (!seen && lat <= 20) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) nbusy++;
        @(negedge clk);
        lat++;
        a = 8'($urandom);
        b = 8'($urandom);
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(W));
    chk("busy_cycles", 32'(nbusy), 32'(W));
    chk("lit_diff", 32'(diff), 32'(ed));
    chk("lit_borrow", 32'(borrow), 32'(eb));
    chk("model_pin", 32'(m_diff), 32'(ed));
`ifdef RESTADOR_SIGNED_OVF_EN
    chk("lit_ovf", 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) chk("ovf_arg", 32'(eo), 32'd0);
`endif
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int cyc;
    int last_done;
    int ndone;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // Continuous start: back-to-back results every W+1 cycles.
    start = 1'b1;
    cyc = 0;
    last_done = -1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ndone++;
        chk("cont_diff", 32'(diff), 32'h0F);
        if (last_done >= 0) chk("cont_period", 32'(cyc - last_done), 32'(W + 1));
        last_done = cyc;
      end
      if (m_rem == 0) begin
        a = 8'h10;
        b = 8'h01;
      end else begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    chk("cont_count", 32'(ndone >= 3), 32'd1);
    start = 1'b0;
    repeat (W + 2) @(negedge clk);

    // Reset in the 4th SHIFT cycle abandons the operation.
    a = 8'h33;
    b = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_diff", 32'(diff), 32'd0);
    chk("mid_rst_borrow", 32'(borrow), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(done), 32'd0);
    end
    run_op(8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

    // Random operations with garbage (and ignored starts) during SHIFT.
    for (int i = 0; i < 500; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      start = 1'b1;
      @(negedge clk);
      for (int j = 0; j < W; j++) begin
        a = 8'($urandom);
        b = 8'($urandom);
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      start = 1'b0;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
